// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
//   Shared types and constants for the clk_div_gen clock/strobe generator.
//   - ch_state_e : per-channel run state (IDLE / RUN / STOP)
//   - ch_cfg_t   : one channel configuration (period, high time, start phase)
//   - CFG_RST    : configuration every channel holds after reset (divide-by-2)
//   - cfg_normalize() : folds illegal field values into legal ones when a
//                       write is accepted, so the channel never sees them.
// -----------------------------------------------------------------------------
package clkgen_pkg;

  // Width of every configuration field and of the per-channel counter.
  localparam int CFG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } ch_cfg_t;

  localparam logic [CFG_W-1:0] RST_PERIOD = CFG_W'(2);
  localparam logic [CFG_W-1:0] RST_HIGH   = CFG_W'(1);
  localparam logic [CFG_W-1:0] RST_PHASE  = CFG_W'(0);

  localparam ch_cfg_t CFG_RST = '{period: RST_PERIOD, high: RST_HIGH, phase: RST_PHASE};

  // Period 0 behaves as period 1; a phase outside the (normalised) period
  // starts the counter at 0. The high time needs no folding: any value at or
  // above the period simply compares as "always high".
  function automatic ch_cfg_t cfg_normalize(input logic [CFG_W-1:0] period,
                                            input logic [CFG_W-1:0] high,
                                            input logic [CFG_W-1:0] phase);
    ch_cfg_t c;
    c.period = (period == '0) ? CFG_W'(1) : period;
    c.high   = high;
    c.phase  = (phase >= c.period) ? '0 : phase;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
//   One channel of the clock/strobe generator: free-running modulo counter,
//   IDLE/RUN/STOP state machine, active + shadow configuration and the
//   pending flag that marks an unapplied shadow.
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   run request (level)
//   wr       in   accepted config write for this channel (already gated)
//   wr_cfg   in   normalised configuration to load into the shadow
//   clk_out  out  registered divided clock
//   tick     out  registered one-cycle strobe while the counter sits at 0
//   running  out  1 while the channel is not IDLE
//   pending  out  shadow holds a config not yet copied to active
// -----------------------------------------------------------------------------
module clk_div_chan
  import clkgen_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    wr,
  input  ch_cfg_t wr_cfg,
  output logic    clk_out,
  output logic    tick,
  output logic    running,
  output logic    pending
);

  ch_state_e        state_reg, state_next;
  logic [CFG_W-1:0] cnt_reg, cnt_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic             pending_reg, pending_next;
  ch_cfg_t          active_reg, active_next;
  ch_cfg_t          shadow_reg, shadow_next;

  logic [CFG_W-1:0] per_last;
  logic             wrap;
  logic             swap;
  logic [CFG_W-1:0] cnt_inc;
  logic [CFG_W-1:0] high_eff;

  // Active period is never 0, so period-1 cannot underflow.
  assign per_last = active_reg.period - CFG_W'(1);
  assign wrap     = (cnt_reg == per_last);
  assign cnt_inc  = wrap ? '0 : cnt_reg + CFG_W'(1);

  // A pending shadow is promoted on the wrap edge, and its high time already
  // decides clk_out for the cnt==0 cycle that this edge starts.
  assign swap     = wrap && pending_reg;
  assign high_eff = swap ? shadow_reg.high : active_reg.high;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
    pending_next = pending_reg;
    active_next  = active_reg;
    shadow_next  = shadow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          // Start uses the active config as it stands; a shadow still pending
          // (or written on this same edge) waits for the first wrap.
          state_next   = ST_RUN;
          cnt_next     = active_reg.phase;
          clk_out_next = (active_reg.phase < active_reg.high);
          tick_next    = (active_reg.phase == '0);
        end else begin
          cnt_next     = '0;
          clk_out_next = 1'b0;
          if (pending_reg) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
          end
        end
      end

      ST_RUN, ST_STOP: begin
        cnt_next     = cnt_inc;
        clk_out_next = (cnt_inc < high_eff);
        tick_next    = (cnt_inc == '0);
        if (swap) begin
          active_next  = shadow_reg;
          pending_next = 1'b0;
        end
        if (state_reg == ST_RUN) begin
          if (!en) begin
            state_next = ST_STOP;
          end
        end else if (en) begin
          // Resume without touching the counter, so no glitch or restart.
          state_next = ST_RUN;
        end else if (wrap) begin
          // Stopping only ever ends on a full period boundary.
          state_next   = ST_IDLE;
          cnt_next     = '0;
          clk_out_next = 1'b0;
          tick_next    = 1'b0;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        cnt_next     = '0;
        clk_out_next = 1'b0;
      end
    endcase

    // A write is only ever accepted while nothing is pending, so it can never
    // collide with the shadow->active copy above.
    if (wr && !pending_reg) begin
      shadow_next  = wr_cfg;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
      active_reg  <= CFG_RST;
      shadow_reg  <= CFG_RST;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
      pending_reg <= pending_next;
      active_reg  <= active_next;
      shadow_reg  <= shadow_next;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign running = (state_reg != ST_IDLE);
  assign pending = pending_reg;

endmodule

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//   Multi-channel programmable clock/strobe generator. Each channel produces a
//   registered divided clock with programmable period, high time and start
//   phase plus a one-cycle wrap strobe. Config writes are shadowed per channel
//   and only take effect at a period boundary (or at once while IDLE).
// Parameters
//   N_CH   number of channels (>=1)
//   CNT_W  width of the config fields and counters; must equal clkgen_pkg::CFG_W
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   cfg_valid   in   config write request
//   cfg_ready   out  write can be accepted (target channel has nothing pending);
//                    forced 1 for channel numbers that do not exist
//   cfg_ch      in   target channel
//   cfg_period  in   period in clk cycles (0 acts as 1)
//   cfg_high    in   high cycles per period (>= period gives constant 1)
//   cfg_phase   in   counter start value (>= period acts as 0)
//   en          in   per-channel run request
//   clk_out     out  per-channel divided clock
//   tick        out  per-channel strobe while counter is 0
//   running     out  per-channel "not IDLE"
// -----------------------------------------------------------------------------
module clk_div_gen
  import clkgen_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = CFG_W,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [N_CH-1:0]  en,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  running
);

  localparam int CH_SPAN = 1 << CH_W;

  ch_cfg_t             norm_cfg;
  logic [N_CH-1:0]     pending_vec;
  logic [CH_SPAN-1:0]  pending_pad;
  logic [N_CH-1:0]     wr_vec;
  logic                ch_ok;
  logic                accept;

  // Normalise once here so every channel receives an already legal config.
  assign norm_cfg = cfg_normalize(cfg_period, cfg_high, cfg_phase);

  // Channel numbers that decode to no channel are dropped silently but still
  // report ready so a writer never stalls on them.
  assign ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));

  // Pad the pending vector to the full cfg_ch range so the ready mux index is
  // always in bounds, whatever N_CH is.
  always_comb begin
    pending_pad             = '0;
    pending_pad[N_CH-1:0]   = pending_vec;
  end

  assign cfg_ready = ch_ok ? ~pending_pad[cfg_ch] : 1'b1;
  assign accept    = cfg_valid && cfg_ready && ch_ok;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign wr_vec[gi] = accept && (cfg_ch == CH_W'(gi));

    clk_div_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[gi]),
      .wr      (wr_vec[gi]),
      .wr_cfg  (norm_cfg),
      .clk_out (clk_out[gi]),
      .tick    (tick[gi]),
      .running (running[gi]),
      .pending (pending_vec[gi])
    );
  end

endmodule
